// File: rtl/adc_acquisition_scheduler_if.sv
// adc_acquisition_scheduler_if: control, ADC-controller and sample-stream signals of the scheduler
interface adc_acquisition_scheduler_if;
    logic        run;
    logic        clear_status;
    logic        adc_start;
    logic        adc_reset;
    logic        adc_data_enable;
    logic        adc_is_error;
    logic [15:0] adc_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_data;
    logic        sample_last;
    logic        busy;
    logic        overrun;
    logic [7:0]  err_count;

    modport master (
        input  run, clear_status, adc_data_enable, adc_is_error, adc_data, sample_ready,
        output adc_start, adc_reset, sample_valid, sample_data, sample_last, busy, overrun, err_count
    );

    modport slave (
        output run, clear_status, adc_data_enable, adc_is_error, adc_data, sample_ready,
        input  adc_start, adc_reset, sample_valid, sample_data, sample_last, busy, overrun, err_count
    );
endinterface

// File: rtl/adc_acquisition_scheduler.sv
// adc_acquisition_scheduler: paces ADC conversions, frames samples into a FWFT FIFO, recovers from errors/timeouts
module adc_acquisition_scheduler #(
    parameter int PERIOD     = 250,
    parameter int FRAME_LEN  = 64,
    parameter int TIMEOUT    = 400,
    parameter int INIT_WAIT  = 2000,
    parameter int FIFO_DEPTH = 16
) (
    input logic clk,
    input logic reset,
    adc_acquisition_scheduler_if.master bus
);
    localparam int PT   = PERIOD > TIMEOUT ? PERIOD : TIMEOUT;
    localparam int MAXC = PT > INIT_WAIT ? PT : INIT_WAIT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam int AW   = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = AW + 1;

    typedef enum logic [2:0] {INIT, IDLE, ARM, START, WAIT_DATA, RECOVER} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [7:0]    errs;
    logic          first, de_prev, rst_pulse, ovr;
    logic          capture, push_ok, pop, enter_rec, is_last;

    // One shared counter: init/recover wait, period since last start, and data timeout
    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            INIT:      if (cnt >= CW'(INIT_WAIT - 1)) state_n = bus.run ? ARM : IDLE;
            IDLE:      if (bus.run) state_n = ARM;
            ARM:       state_n = bus.adc_is_error ? RECOVER : !bus.run ? IDLE :
                                 (first || cnt >= CW'(PERIOD - 1)) ? START : ARM;
            START:     state_n = bus.adc_is_error ? RECOVER : WAIT_DATA;
            WAIT_DATA: begin
                capture = !bus.adc_is_error && bus.adc_data_enable && !de_prev;
                state_n = bus.adc_is_error ? RECOVER : capture ? (bus.run ? ARM : IDLE) :
                          cnt >= CW'(TIMEOUT - 1) ? RECOVER : WAIT_DATA;
            end
            RECOVER:   if (cnt >= CW'(INIT_WAIT - 1)) state_n = bus.run ? ARM : IDLE;
            default:   state_n = INIT;
        endcase
    end

    assign enter_rec = state_n == RECOVER && state != RECOVER;
    assign is_last   = idx == IW'(FRAME_LEN - 1);
    assign pop       = count != '0 && bus.sample_ready;
    assign push_ok   = capture && (count < NW'(FIFO_DEPTH) || pop);

    // Recovery entry counts as its first wait cycle so the restart lands INIT_WAIT cycles after adc_reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= '0;
            idx       <= '0;
            first     <= 1'b1;
            de_prev   <= 1'b0;
            rst_pulse <= 1'b0;
            errs      <= '0;
            ovr       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= state_n == START ? '0 : enter_rec ? CW'(1) : cnt == CW'(MAXC) ? cnt : cnt + 1'b1;
            first     <= state_n == START ? 1'b0 : state inside {INIT, IDLE, RECOVER} ? 1'b1 : first;
            idx       <= capture ? (is_last ? '0 : idx + 1'b1) : state == IDLE ? '0 : idx;
            de_prev   <= bus.adc_data_enable;
            rst_pulse <= enter_rec;
            errs      <= enter_rec ? errs + {7'd0, errs != 8'hFF} : bus.clear_status ? '0 : errs;
            ovr       <= (capture && !push_ok) ? 1'b1 : bus.clear_status ? 1'b0 : ovr;
            wr_ptr    <= wr_ptr + AW'(push_ok);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + NW'(push_ok) - NW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {is_last, bus.adc_data};
    end

    assign bus.adc_start    = state == START;
    assign bus.adc_reset    = rst_pulse;
    assign bus.busy         = state != IDLE;
    assign bus.overrun      = ovr;
    assign bus.err_count    = errs;
    assign bus.sample_valid = count != '0;
    assign bus.sample_data  = mem[rd_ptr][15:0];
    assign bus.sample_last  = mem[rd_ptr][16];
endmodule
